// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC issue/dispatch controller.
// Entry layout matches the default 64-bit, 4-bit-id configuration.
package ecc_ctrl_pkg;

    localparam logic [2:0] ECC_F3_SETMOD = 3'b000;
    localparam logic [2:0] ECC_F3_ADD    = 3'b001;
    localparam logic [2:0] ECC_F3_SUB    = 3'b010;

    localparam logic [5:0] ECC_EXC_ILLEGAL = 6'd2;

    localparam int unsigned ECC_WIDTH = 64;
    localparam int unsigned ECC_ID_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSetmod,
        StExec,
        StResp
    } ecc_ctrl_state_e;

    typedef struct packed {
        logic [2:0]           funct3;
        logic [4:0]           rd;
        logic [ECC_ID_W-1:0]  id;
        logic [ECC_WIDTH-1:0] rs1;
        logic [ECC_WIDTH-1:0] rs2;
    } ecc_entry_t;

endpackage

// File: rtl/ecc_issue_fifo.sv
// In-order issue queue for the ECC controller; DEPTH must be a power of two.
module ecc_issue_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ecc_issue_ctrl.sv
// ECC coprocessor issue/dispatch controller: queues offloaded instructions, dispatches
// them in order and returns results with backpressure. ECC_ILLEGAL_EXC_EN raises exceptions.
module ecc_issue_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [31:0]      issue_instr_i,
    input  logic [WIDTH-1:0] issue_rs1_i,
    input  logic [WIDTH-1:0] issue_rs2_i,
    input  logic [ID_W-1:0]  issue_id_i,
    output logic             op_start_o,
    output logic             op_sub_o,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    input  logic             op_done_i,
    input  logic [WIDTH-1:0] op_result_i,
    output logic [WIDTH-1:0] modulus_o,
    output logic             modulus_we_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_data_o,
    output logic [ID_W-1:0]  result_id_o,
    output logic [4:0]       result_rd_o,
    output logic             result_we_o,
    output logic             result_exc_o,
    output logic [5:0]       result_exccode_o
);

    typedef struct packed {
        logic [2:0]       funct3;
        logic [4:0]       rd;
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] rs1;
        logic [WIDTH-1:0] rs2;
    } entry_t;

    entry_t push_ent, head;
    logic   fifo_full, fifo_empty, fifo_pop;
    logic   unused_instr;

    ecc_ctrl_state_e  state_q, state_d;
    logic [4:0]       cur_rd_q, cur_rd_d;
    logic [WIDTH-1:0] cur_rs1_q, cur_rs1_d;
    logic             op_start_q, op_start_d, op_sub_q, op_sub_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] modulus_q, modulus_d;
    logic             modulus_we_q, modulus_we_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [4:0]       res_rd_q, res_rd_d;
    logic             res_we_q, res_we_d, res_exc_q, res_exc_d;
    logic [5:0]       res_exccode_q, res_exccode_d;

    assign unused_instr = ^{issue_instr_i[31:15], issue_instr_i[6:0]};
    assign push_ent = '{funct3: issue_instr_i[14:12], rd: issue_instr_i[11:7], id: issue_id_i,
                        rs1: issue_rs1_i, rs2: issue_rs2_i};

    ecc_issue_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (issue_valid_i),
        .wdata_i(push_ent),
        .pop_i  (fifo_pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        cur_rd_d      = cur_rd_q;
        cur_rs1_d     = cur_rs1_q;
        op_start_d    = 1'b0;
        op_sub_d      = op_sub_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        modulus_d     = modulus_q;
        modulus_we_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_id_d      = res_id_q;
        res_rd_d      = res_rd_q;
        res_we_d      = res_we_q;
        res_exc_d     = res_exc_q;
        res_exccode_d = res_exccode_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cur_rd_d  = head.rd;
                    cur_rs1_d = head.rs1;
                    res_id_d  = head.id;
                    case (head.funct3)
                        ECC_F3_ADD, ECC_F3_SUB: begin
                            state_d    = StExec;
                            op_start_d = 1'b1;
                            op_sub_d   = (head.funct3 == ECC_F3_SUB);
                            op_a_d     = head.rs1;
                            op_b_d     = head.rs2;
                        end
                        ECC_F3_SETMOD: state_d = StSetmod;
                        default: begin
                            state_d    = StResp;
                            res_data_d = '0;
                            res_rd_d   = '0;
                            res_we_d   = 1'b0;
`ifdef ECC_ILLEGAL_EXC_EN
                            res_exc_d     = 1'b1;
                            res_exccode_d = ECC_EXC_ILLEGAL;
`else
                            res_exc_d     = 1'b0;
                            res_exccode_d = '0;
`endif
                        end
                    endcase
                end
            end
            StSetmod: begin
                modulus_d     = cur_rs1_q;
                modulus_we_d  = 1'b1;
                res_data_d    = '0;
                res_rd_d      = '0;
                res_we_d      = 1'b0;
                res_exc_d     = 1'b0;
                res_exccode_d = '0;
                state_d       = StResp;
            end
            StExec: begin
                // A done pulse coinciding with the start cycle is not ours.
                if (op_done_i && !op_start_q) begin
                    res_data_d    = op_result_i;
                    res_rd_d      = cur_rd_q;
                    res_we_d      = 1'b1;
                    res_exc_d     = 1'b0;
                    res_exccode_d = '0;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (res_valid_q && result_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cur_rd_q      <= '0;
            cur_rs1_q     <= '0;
            op_start_q    <= 1'b0;
            op_sub_q      <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            modulus_q     <= '0;
            modulus_we_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_id_q      <= '0;
            res_rd_q      <= '0;
            res_we_q      <= 1'b0;
            res_exc_q     <= 1'b0;
            res_exccode_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_rd_q      <= cur_rd_d;
            cur_rs1_q     <= cur_rs1_d;
            op_start_q    <= op_start_d;
            op_sub_q      <= op_sub_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            modulus_q     <= modulus_d;
            modulus_we_q  <= modulus_we_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_id_q      <= res_id_d;
            res_rd_q      <= res_rd_d;
            res_we_q      <= res_we_d;
            res_exc_q     <= res_exc_d;
            res_exccode_q <= res_exccode_d;
        end
    end

    assign issue_ready_o    = !fifo_full;
    assign op_start_o       = op_start_q;
    assign op_sub_o         = op_sub_q;
    assign op_a_o           = op_a_q;
    assign op_b_o           = op_b_q;
    assign modulus_o        = modulus_q;
    assign modulus_we_o     = modulus_we_q;
    assign result_valid_o   = res_valid_q;
    assign result_data_o    = res_data_q;
    assign result_id_o      = res_id_q;
    assign result_rd_o      = res_rd_q;
    assign result_we_o      = res_we_q;
    assign result_exc_o     = res_exc_q;
    assign result_exccode_o = res_exccode_q;

endmodule

// File: tb/tb_ecc_issue_ctrl.sv
// Directed self-checking bench for ecc_issue_ctrl (default 64-bit, depth-4 configuration).
module tb_ecc_issue_ctrl;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = 4;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [31:0]      issue_instr = '0;
    logic [WIDTH-1:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [ID_W-1:0]  issue_id = '0;
    logic             op_start, op_sub;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_done = 1'b0;
    logic [WIDTH-1:0] op_result = '0;
    logic [WIDTH-1:0] modulus;
    logic             modulus_we;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [WIDTH-1:0] result_data;
    logic [ID_W-1:0]  result_id;
    logic [4:0]       result_rd;
    logic             result_we, result_exc;
    logic [5:0]       result_exccode;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_mwe = 0;

    ecc_issue_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ID_W (ID_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .issue_instr_i   (issue_instr),
        .issue_rs1_i     (issue_rs1),
        .issue_rs2_i     (issue_rs2),
        .issue_id_i      (issue_id),
        .op_start_o      (op_start),
        .op_sub_o        (op_sub),
        .op_a_o          (op_a),
        .op_b_o          (op_b),
        .op_done_i       (op_done),
        .op_result_i     (op_result),
        .modulus_o       (modulus),
        .modulus_we_o    (modulus_we),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .result_data_o   (result_data),
        .result_id_o     (result_id),
        .result_rd_o     (result_rd),
        .result_we_o     (result_we),
        .result_exc_o    (result_exc),
        .result_exccode_o(result_exccode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_start) n_start++;
        if (modulus_we) n_mwe++;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; a pending push is retired once the DUT has taken it.
    task automatic tick();
        logic acc;
        acc = issue_valid && issue_ready;
        @(posedge clk);
        #1;
        if (acc) issue_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] f3, input logic [4:0] rd, input logic [ID_W-1:0] id,
                        input logic [WIDTH-1:0] rs1, input logic [WIDTH-1:0] rs2);
        issue_instr = {17'd0, f3, rd, 7'b0101011};
        issue_id    = id;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_valid = 1'b1;
        for (int i = 0; i < 40 && issue_valid; i++) tick();
        check_val("push_accepted", 128'(issue_valid), 128'(0));
        issue_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 20 && !op_start; i++) tick();
        check_val(tag, 128'(op_start), 128'(1));
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !result_valid; i++) tick();
        check_val(tag, 128'(result_valid), 128'(1));
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_val("valid_after_hs", 128'(result_valid), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [127:0] snap;

        // Reset state
        #1 rst_ni = 1'b0;
        #2;
        check_val("rst_ready", 128'(issue_ready), 128'(1));
        check_val("rst_outs", 128'({op_start, op_sub, modulus_we, result_valid, result_we,
                                     result_exc, result_exccode, result_id, result_rd}), 128'(0));
        check_val("rst_modulus", 128'(modulus), 128'(0));
        @(posedge clk);
        #1 rst_ni = 1'b1;
        tick();

        // SETMOD rs1=0x11 id=3: modulus after t+2, valid from t+3
        push(3'b000, 5'd0, 4'd3, 64'h11, 64'h0);
        tick();
        tick();
        check_val("setmod_we", 128'(modulus_we), 128'(1));
        check_val("setmod_mod", 128'(modulus), 128'h11);
        tick();
        check_val("setmod_valid", 128'(result_valid), 128'(1));
        check_val("setmod_resp", 128'({result_id, result_we, result_data}), 128'({4'd3, 1'b0, 64'd0}));
        handshake();
        check_val("setmod_we_pulses", 128'(n_mwe), 128'(1));

        // Done outside EXEC is ignored
        op_done = 1'b1;
        op_result = 64'hbad;
        tick();
        op_done = 1'b0;
        tick();
        check_val("idle_done_ignored", 128'(result_valid), 128'(0));

        // ADD 5+7 -> 12, rd=9; a done in the start cycle must be ignored
        s0 = n_start;
        push(3'b001, 5'd9, 4'd6, 64'd5, 64'd7);
        tick();
        check_val("add_start", 128'({op_start, op_sub, op_a, op_b}), 128'({1'b1, 1'b0, 64'd5, 64'd7}));
        op_done = 1'b1;
        op_result = 64'd99;
        tick();
        op_done = 1'b0;
        check_val("add_start_pulse", 128'(op_start), 128'(0));
        tick();
        check_val("add_no_early_resp", 128'(result_valid), 128'(0));
        op_done = 1'b1;
        op_result = 64'd12;
        tick();
        op_done = 1'b0;
        wait_valid("add_valid");
        check_val("add_resp", 128'({result_id, result_rd, result_we, result_exc, result_data}),
                  128'({4'd6, 5'd9, 1'b1, 1'b0, 64'd12}));
        check_val("add_one_start", 128'(n_start - s0), 128'(1));
        handshake();

        // Fill queue behind a stalled SUB, then retire ids 0..5 in order
        push(3'b010, 5'd1, 4'd0, 64'd100, 64'd0);
        tick();
        check_val("sub_start", 128'({op_start, op_sub}), 128'({1'b1, 1'b1}));
        for (int k = 1; k <= DEPTH; k++) push(3'b010, 5'(k + 1), 4'(k), 64'(100 + k), 64'(k));
        check_val("full_ready_low", 128'(issue_ready), 128'(0));
        issue_instr = {17'd0, 3'b010, 5'd6, 7'b0101011};
        issue_id    = 4'd5;
        issue_rs1   = 64'd105;
        issue_rs2   = 64'd5;
        issue_valid = 1'b1;
        tick();
        tick();
        check_val("full_no_push", 128'({issue_ready, issue_valid}), 128'({1'b0, 1'b1}));

        for (int k = 0; k <= DEPTH + 1; k++) begin
            if (k != 0) begin
                wait_start("q_start");
                check_val("q_operands", 128'({op_sub, op_a, op_b}), 128'({1'b1, 64'(100 + k), 64'(k)}));
            end
            tick();
            op_done = 1'b1;
            op_result = 64'h1000 + 64'(k);
            tick();
            op_done = 1'b0;
            wait_valid("q_valid");
            check_val("q_order", 128'({result_id, result_rd, result_we, result_data}),
                      128'({4'(k), 5'(k + 1), 1'b1, 64'h1000 + 64'(k)}));
            if (k == 0) begin
                s0 = n_start;
                snap = 128'({1'b1, 1'b1, 5'd1, 4'd0, 64'h1000});
                for (int c = 0; c < 10; c++) begin
                    tick();
                    check_val("stall_stable", 128'({result_valid, result_we, result_rd, result_id,
                                                    result_data}), snap);
                end
                check_val("stall_no_start", 128'(n_start - s0), 128'(0));
            end
            handshake();
        end

        // Illegal funct3=111, id=5
        push(3'b111, 5'd3, 4'd5, 64'hdead, 64'h0);
        wait_valid("ill_valid");
`ifdef ECC_ILLEGAL_EXC_EN
        check_val("ill_exc", 128'({result_exc, result_exccode}), 128'({1'b1, 6'd2}));
`else
        check_val("ill_exc", 128'({result_exc, result_exccode}), 128'({1'b0, 6'd0}));
`endif
        check_val("ill_resp", 128'({result_id, result_we, result_data}), 128'({4'd5, 1'b0, 64'd0}));
        handshake();

        // Reset during EXEC with two queued entries
        push(3'b001, 5'd4, 4'd1, 64'd1, 64'd2);
        wait_start("rst_exec_start");
        push(3'b001, 5'd5, 4'd2, 64'd3, 64'd4);
        push(3'b010, 5'd6, 4'd3, 64'd5, 64'd6);
        check_val("rst_pre_ready", 128'(issue_ready), 128'(1));
        rst_ni = 1'b0;
        #1;
        check_val("rst_mid_modulus", 128'(modulus), 128'(0));
        check_val("rst_mid_ops", 128'({op_start, op_sub, op_a, op_b}), 128'(0));
        check_val("rst_mid_res", 128'({result_valid, result_id, result_rd, result_we, result_data}),
                  128'(0));
        tick();
        rst_ni = 1'b1;
        check_val("rst_rel_ready", 128'(issue_ready), 128'(1));
        s0 = n_start;
        op_done = 1'b1;
        op_result = 64'h77;
        tick();
        op_done = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check_val("rst_no_stale", 128'({result_valid, 32'(n_start - s0)}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
